i2c_cmd_sequencer: RTL and testbench

- Command-queue front end that sits directly upstream of i2c_controller and drives its en/peripheral_address/target_register/rw/din inputs.
- Consumes its busy/dout outputs and returns one response per command.
- Buffers host commands in a small FIFO and issues them to the controller one at a time.
- Provides a per-transaction timeout so a stuck bus cannot hang the host.

---
 rtl/i2c_cmd_sequencer.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_cmd_sequencer
//
// Command-queue front end for i2c_controller. Host commands are buffered in a
// small FIFO and launched one at a time. The controller's en/address/register/
// rw/din inputs are driven from here. Its busy flag is synchronised and
// watched. Exactly one response is returned per launched command, in command
// order. A per-transaction timer aborts a transaction whose busy handshake
// never completes, so a stuck bus cannot hang the host.
//
// Parameters
//   DEPTH           command FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  clk cycles allowed from launch until busy falls
//   SYNC_STAGES     flops in the ctrl_busy synchroniser (>= 2)
//
// Ports
//   clk, rst_n                  system clock, async active-low reset
//   cmd_valid/cmd_ready         host command handshake
//   cmd_addr/reg/rw/data        command fields (data ignored for reads)
//   rsp_valid                   one-cycle response strobe, no backpressure
//   rsp_data                    read data; 0 for writes and timeouts
//   rsp_timeout                 qualifies rsp_valid: transaction aborted
//   ctrl_en                     controller enable, high only while launching
//   ctrl_peripheral_address,
//   ctrl_target_register,
//   ctrl_rw, ctrl_din           held command fields to the controller
//   ctrl_busy                   controller busy (asynchronous, dclk domain)
//   ctrl_dout                   controller read data, stable once busy falls
//   fifo_level                  number of queued commands
//   idle                        FIFO empty and sequencer idle
// -----------------------------------------------------------------------------
module i2c_cmd_sequencer #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [6:0]                cmd_addr,
    input  logic [7:0]                cmd_reg,
    input  logic                      cmd_rw,
    input  logic [15:0]               cmd_data,
    output logic                      rsp_valid,
    output logic [15:0]               rsp_data,
    output logic                      rsp_timeout,
    output logic                      ctrl_en,
    output logic [6:0]                ctrl_peripheral_address,
    output logic [7:0]                ctrl_target_register,
    output logic                      ctrl_rw,
    output logic [15:0]               ctrl_din,
    input  logic                      ctrl_busy,
    input  logic [15:0]               ctrl_dout,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      idle
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    // Packed FIFO entry: {addr[6:0], reg[7:0], rw, data[15:0]}
    localparam int EW = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_ACTIVE = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4
    } state_t;

    state_t                 state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   busy_s;

    logic [EW-1:0]          mem_q [DEPTH];
    logic [EW-1:0]          mem_d [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;

    logic [TW-1:0]          timer_q, timer_d;
    logic                   timer_expired_s;

    logic                   ctrl_en_q, ctrl_en_d;
    logic [6:0]             ctrl_addr_q, ctrl_addr_d;
    logic [7:0]             ctrl_reg_q, ctrl_reg_d;
    logic                   ctrl_rw_q, ctrl_rw_d;
    logic [15:0]            ctrl_din_q, ctrl_din_d;

    logic                   rsp_valid_q, rsp_valid_d;
    logic                   rsp_timeout_q, rsp_timeout_d;
    logic [15:0]            rsp_data_q, rsp_data_d;

    logic                   push_s;
    logic                   pop_s;
    logic [EW-1:0]          entry_s;
    logic [EW-1:0]          head_s;

    // Handshake and FIFO status decoded from the level counter
    assign cmd_ready       = (level_q != LW'(DEPTH));
    assign push_s          = cmd_valid && cmd_ready;
    // A command is only ever popped on the IDLE -> LAUNCH transition
    assign pop_s           = (state_q == ST_IDLE) && (level_q != {LW{1'b0}});
    assign entry_s         = {cmd_addr, cmd_reg, cmd_rw, cmd_data};
    assign head_s          = mem_q[rd_ptr_q];
    assign busy_s          = sync_q[SYNC_STAGES-1];
    assign timer_expired_s = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    assign fifo_level              = level_q;
    assign idle                    = (level_q == {LW{1'b0}}) && (state_q == ST_IDLE);
    assign ctrl_en                 = ctrl_en_q;
    assign ctrl_peripheral_address = ctrl_addr_q;
    assign ctrl_target_register    = ctrl_reg_q;
    assign ctrl_rw                 = ctrl_rw_q;
    assign ctrl_din                = ctrl_din_q;
    assign rsp_valid               = rsp_valid_q;
    assign rsp_timeout             = rsp_timeout_q;
    assign rsp_data                = rsp_data_q;

    // Shift chain bringing ctrl_busy into the clk domain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], ctrl_busy};
    end

    // Synchroniser flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; timeout wins over a same-cycle busy edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    state_d = ST_LAUNCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (timer_expired_s) begin
                    state_d = ST_ABORT;
                end else if (busy_s) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_ACTIVE: begin
                if (timer_expired_s) begin
                    state_d = ST_ABORT;
                end else if (!busy_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs and datapath next values (all outputs are registered)
    always_comb begin
        // ctrl_en and the response strobe follow the state being entered, so
        // their flops are high exactly while the FSM sits in that state.
        ctrl_en_d     = (state_d == ST_LAUNCH);
        rsp_valid_d   = (state_d == ST_DONE) || (state_d == ST_ABORT);
        rsp_timeout_d = (state_d == ST_ABORT);
        if ((state_d == ST_DONE) && ctrl_rw_q) begin
            rsp_data_d = ctrl_dout;
        end else begin
            rsp_data_d = 16'h0000;
        end

        // Held command fields change only when a new command is popped
        if (pop_s) begin
            ctrl_addr_d = head_s[31:25];
            ctrl_reg_d  = head_s[24:17];
            ctrl_rw_d   = head_s[16];
            ctrl_din_d  = head_s[15:0];
        end else begin
            ctrl_addr_d = ctrl_addr_q;
            ctrl_reg_d  = ctrl_reg_q;
            ctrl_rw_d   = ctrl_rw_q;
            ctrl_din_d  = ctrl_din_q;
        end

        // Transaction timer runs across LAUNCH and ACTIVE without restarting
        case (state_q)
            ST_IDLE: timer_d = {TW{1'b0}};
            ST_LAUNCH, ST_ACTIVE: begin
                if (timer_expired_s) begin
                    timer_d = timer_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: timer_d = timer_q;
        endcase
    end

    // FIFO pointer and level next values; pointers wrap modulo DEPTH
    always_comb begin
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = entry_s;
        end else begin
            mem_d = mem_q;
        end
    end

    // FIFO storage flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {EW{1'b0}};
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Datapath, FIFO control and registered output flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            level_q       <= {LW{1'b0}};
            timer_q       <= {TW{1'b0}};
            ctrl_en_q     <= 1'b0;
            ctrl_addr_q   <= 7'h00;
            ctrl_reg_q    <= 8'h00;
            ctrl_rw_q     <= 1'b0;
            ctrl_din_q    <= 16'h0000;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_data_q    <= 16'h0000;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            timer_q       <= timer_d;
            ctrl_en_q     <= ctrl_en_d;
            ctrl_addr_q   <= ctrl_addr_d;
            ctrl_reg_q    <= ctrl_reg_d;
            ctrl_rw_q     <= ctrl_rw_d;
            ctrl_din_q    <= ctrl_din_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
            rsp_data_q    <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
module tb_i2c_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 16;
    localparam int SYNC  = 2;

    // Addresses the controller model treats as a hung bus
    localparam logic [6:0] A_STUCK_LOW  = 7'h7F;
    localparam logic [6:0] A_STUCK_HIGH = 7'h7E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_reg;
    logic        cmd_rw;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        ctrl_en;
    logic [6:0]  ctrl_peripheral_address;
    logic [7:0]  ctrl_target_register;
    logic        ctrl_rw;
    logic [15:0] ctrl_din;
    logic        ctrl_busy;
    logic [15:0] ctrl_dout;
    logic [2:0]  fifo_level;
    logic        idle;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_reg(cmd_reg), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .ctrl_en(ctrl_en), .ctrl_peripheral_address(ctrl_peripheral_address),
        .ctrl_target_register(ctrl_target_register), .ctrl_rw(ctrl_rw),
        .ctrl_din(ctrl_din), .ctrl_busy(ctrl_busy), .ctrl_dout(ctrl_dout),
        .fifo_level(fifo_level), .idle(idle)
    );

    typedef struct packed {
        logic [6:0]  addr;
        logic [7:0]  rg;
        logic        rw;
        logic [15:0] data;
    } cmd_t;

    typedef struct packed {
        cmd_t        c;
        logic        exp_to;
        logic [15:0] exp_data;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_true(input string name, input bit cond);
        n_checks++;
        if (!cond) begin
            n_fail++;
            $display("FAIL %s: condition false (t=%0t)", name, $time);
        end
    endtask

    // Read data the modelled controller returns for a given address/register
    function automatic logic [15:0] dout_of(input logic [6:0] a, input logic [7:0] r);
        if (a == 7'h48 && r == 8'h00) begin
            return 16'h1234;
        end else begin
            return {r, 1'b0, a};
        end
    endfunction

    // Expected {timeout, data} response for a command
    function automatic logic [16:0] exp_rsp(input cmd_t c);
        if (c.addr == A_STUCK_LOW || c.addr == A_STUCK_HIGH) begin
            return {1'b1, 16'h0000};
        end else if (c.rw) begin
            return {1'b0, dout_of(c.addr, c.rg)};
        end else begin
            return {1'b0, 16'h0000};
        end
    endfunction

    // ------------------------------------------------------------------
    // Controller model: acknowledges ctrl_en with a busy pulse, or hangs
    // ------------------------------------------------------------------
    initial begin : ctrl_model
        logic [6:0] a;
        logic [7:0] r;
        ctrl_busy = 1'b0;
        ctrl_dout = 16'h0000;
        forever begin
            @(negedge clk);
            if (ctrl_en) begin
                a = ctrl_peripheral_address;
                r = ctrl_target_register;
                if (a == A_STUCK_LOW) begin
                    for (int k = 0; k < 200 && ctrl_en; k++) @(negedge clk);
                end else begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    #2 ctrl_busy = 1'b1;
                    for (int k = 0; k < 200 && ctrl_en; k++) @(negedge clk);
                    if (a == A_STUCK_HIGH) begin
                        for (int k = 0; k < 200 && !rsp_valid && rst_n; k++) @(negedge clk);
                    end else begin
                        repeat ($urandom_range(1, 4)) @(negedge clk);
                    end
                    ctrl_dout = dout_of(a, r);
                    #1 ctrl_busy = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model / scoreboard, evaluated mid-cycle
    // ------------------------------------------------------------------
    cmd_t mq[$];
    cmd_t cur;
    cmd_t pend_cmd;
    int   m_level  = 0;
    bit   txn_active = 1'b0;
    bit   en_prev  = 1'b0;
    bit   push_pend = 1'b0;
    bit   saw_full = 1'b0;
    int   en_len   = 0;
    int   n_push   = 0;
    int   n_rsp    = 0;
    int   n_rsp_seen = 0;

    always @(negedge clk) begin
        if (rsp_valid) n_rsp_seen++;
        if (!rst_n) begin
            mq.delete();
            m_level    = 0;
            txn_active = 1'b0;
            en_prev    = 1'b0;
            push_pend  = 1'b0;
            en_len     = 0;
            chk_eq("ctrl_en in reset", {31'h0, ctrl_en}, 32'h0);
            chk_eq("rsp_valid in reset", {31'h0, rsp_valid}, 32'h0);
        end else begin
            if (push_pend) begin
                mq.push_back(pend_cmd);
                m_level++;
                n_push++;
            end
            if (ctrl_en && !en_prev) begin
                chk_true("launch has a queued command", mq.size() > 0);
                if (mq.size() > 0) begin
                    cur        = mq.pop_front();
                    m_level--;
                    txn_active = 1'b1;
                    en_len     = 0;
                end
            end
            if (ctrl_en) begin
                en_len++;
                chk_true("ctrl_en only inside a transaction", txn_active);
                chk_true("ctrl_en high at most TIMEOUT cycles", en_len <= TMO);
            end
            if (txn_active) begin
                chk_eq("ctrl fields", {ctrl_peripheral_address, ctrl_target_register,
                                       ctrl_rw, ctrl_din}, cur);
            end
            chk_eq("fifo_level", {29'h0, fifo_level}, m_level);
            chk_eq("cmd_ready", {31'h0, cmd_ready}, {31'h0, m_level != DEPTH});
            chk_eq("idle", {31'h0, idle}, {31'h0, (m_level == 0) && !txn_active});
            if (m_level == DEPTH && !cmd_ready) saw_full = 1'b1;
            if (rsp_valid) begin
                chk_true("rsp_valid belongs to a transaction", txn_active);
                if (txn_active) begin
                    chk_eq("response {timeout,data}", {rsp_timeout, rsp_data}, exp_rsp(cur));
                    if (cur.addr == A_STUCK_LOW) begin
                        chk_eq("ctrl_en cycles before timeout", en_len, TMO);
                    end
                    txn_active = 1'b0;
                    n_rsp++;
                end
            end
            en_prev   = ctrl_en;
            push_pend = cmd_valid && cmd_ready;
            pend_cmd  = {cmd_addr, cmd_reg, cmd_rw, cmd_data};
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks (all return at posedge + 1)
    // ------------------------------------------------------------------
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_cmd(input cmd_t c);
        int k;
        cmd_valid = 1'b1;
        cmd_addr  = c.addr;
        cmd_reg   = c.rg;
        cmd_rw    = c.rw;
        cmd_data  = c.data;
        k = 0;
        while (!cmd_ready && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk_true("push accepted within bound", cmd_ready);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit got, output logic to, output logic [15:0] d);
        got = 1'b0;
        to  = 1'b0;
        d   = 16'h0000;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                to  = rsp_timeout;
                d   = rsp_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (!(idle && !ctrl_busy) && k < 3000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk_true(name, idle && !ctrl_busy);
        cycles(3);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Main stimulus
    // ------------------------------------------------------------------
    vec_t vecs [7];
    cmd_t c;
    bit   got;
    logic to;
    logic [15:0] d;
    int   push0;
    int   rsp0;
    int   seen0;
    bit   seen_en;

    initial begin : main
        cmd_valid = 1'b0;
        cmd_addr  = 7'h00;
        cmd_reg   = 8'h00;
        cmd_rw    = 1'b0;
        cmd_data  = 16'h0000;

        // Reset state
        #1;
        chk_eq("reset cmd_ready", {31'h0, cmd_ready}, 32'h1);
        chk_eq("reset idle", {31'h0, idle}, 32'h1);
        chk_eq("reset fifo_level", {29'h0, fifo_level}, 32'h0);
        chk_eq("reset ctrl_en/rsp", {29'h0, ctrl_en, rsp_valid, rsp_timeout}, 32'h0);
        chk_eq("reset rsp_data", {16'h0, rsp_data}, 32'h0);
        chk_eq("reset ctrl fields", {ctrl_peripheral_address, ctrl_target_register,
                                     ctrl_rw, ctrl_din}, 32'h0);
        cycles(3);
        rst_n = 1'b1;
        cycles(2);

        // Table-driven single transactions
        vecs[0] = {7'h48, 8'h01, 1'b0, 16'hA55A, 1'b0, 16'h0000};
        vecs[1] = {7'h48, 8'h00, 1'b1, 16'h0000, 1'b0, 16'h1234};
        vecs[2] = {7'h3C, 8'h5A, 1'b1, 16'hFFFF, 1'b0, 16'h5A3C};
        vecs[3] = {7'h11, 8'h22, 1'b0, 16'h0F0F, 1'b0, 16'h0000};
        vecs[4] = {7'h7F, 8'h10, 1'b0, 16'hBEEF, 1'b1, 16'h0000};
        vecs[5] = {7'h7E, 8'h20, 1'b1, 16'h0000, 1'b1, 16'h0000};
        vecs[6] = {7'h00, 8'hFF, 1'b1, 16'h0001, 1'b0, 16'hFF00};
        for (int i = 0; i < 7; i++) begin
            push_cmd(vecs[i].c);
            wait_rsp(got, to, d);
            chk_true($sformatf("vec%0d response seen", i), got);
            chk_eq($sformatf("vec%0d rsp_timeout", i), {31'h0, to}, {31'h0, vecs[i].exp_to});
            chk_eq($sformatf("vec%0d rsp_data", i), {16'h0, d}, {16'h0, vecs[i].exp_data});
            drain($sformatf("vec%0d drained", i));
        end

        // Fill the FIFO while the first command is in flight
        saw_full = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = {7'h20 + 7'(i), 8'h40 + 8'(i), 1'(i % 2), 16'h1000 + 16'(i)};
            push_cmd(c);
        end
        drain("fill drained");
        chk_true("FIFO reached full with cmd_ready low", saw_full);

        // Timeout followed by a queued command
        push_cmd({A_STUCK_LOW, 8'h05, 1'b1, 16'h0000});
        push_cmd({7'h48, 8'h00, 1'b1, 16'h0000});
        wait_rsp(got, to, d);
        chk_eq("timeout rsp {seen,to,data}", {15'h0, got, to, d}, {15'h0, 1'b1, 1'b1, 16'h0000});
        wait_rsp(got, to, d);
        chk_eq("post-timeout rsp {seen,to,data}", {15'h0, got, to, d}, {15'h0, 1'b1, 1'b0, 16'h1234});
        drain("timeout drained");

        // Push in the same cycle as the pop at level 1
        push_cmd({7'h0A, 8'h01, 1'b0, 16'h1111});
        push_cmd({7'h0B, 8'h02, 1'b1, 16'h2222});
        chk_eq("push/pop level", {29'h0, fifo_level}, 32'h1);
        chk_eq("push/pop launch addr", {25'h0, ctrl_peripheral_address}, 32'h0A);
        chk_eq("push/pop ctrl_en", {31'h0, ctrl_en}, 32'h1);
        drain("push/pop drained");

        // Reset while ACTIVE with two commands queued
        push_cmd({7'h33, 8'h01, 1'b1, 16'h0000});
        push_cmd({7'h34, 8'h02, 1'b0, 16'h5555});
        push_cmd({7'h35, 8'h03, 1'b0, 16'h6666});
        seen_en = 1'b0;
        for (int k = 0; k < 100 && !(seen_en && !ctrl_en); k++) begin
            @(negedge clk);
            if (ctrl_en) seen_en = 1'b1;
        end
        chk_true("reached ACTIVE", seen_en && !ctrl_en);
        chk_eq("level before reset", {29'h0, fifo_level}, 32'h2);
        seen0 = n_rsp_seen;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_eq("mid reset ctrl_en", {31'h0, ctrl_en}, 32'h0);
        chk_eq("mid reset fifo_level", {29'h0, fifo_level}, 32'h0);
        chk_eq("mid reset idle", {31'h0, idle}, 32'h1);
        cycles(3);
        rst_n = 1'b1;
        cycles(20);
        chk_eq("no response after mid reset", n_rsp_seen, seen0);
        drain("reset drained");

        // Randomised traffic against the scoreboard
        push0 = n_push;
        rsp0  = n_rsp;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       c.addr = A_STUCK_LOW;
                1:       c.addr = A_STUCK_HIGH;
                default: c.addr = 7'($urandom_range(0, 125));
            endcase
            c.rg   = 8'($urandom);
            c.rw   = 1'($urandom);
            c.data = 16'($urandom);
            push_cmd(c);
            cycles($urandom_range(0, 3));
        end
        drain("random drained");
        chk_eq("random response count", n_rsp - rsp0, n_push - push0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
